// File: rtl/outport_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : outport_grant_ctrl
// Brief    : Credit-gated switch-allocation control around a multistage
//            matrix_arb; optional wormhole lock via OUTPORT_GRANT_CTRL_PKT_LOCK_EN.
// Revision : 1.0
// ============================================================================
module outport_grant_ctrl #(
    parameter int SIZE         = 4,
    parameter int CREDIT_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  req_in,
    input  logic [SIZE-1:0]  tail_in,
    output logic [SIZE-1:0]  arb_request,
    input  logic [SIZE-1:0]  arb_grant,
    output logic             arb_success,
    output logic [SIZE-1:0]  deq,
    output logic [SIZE-1:0]  sel,
    output logic             flit_valid,
    input  logic             credit_in,
    output logic [CNT_W-1:0] credits,
    output logic             busy,
    output logic             err
);

    localparam int               c_idx_w = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(CREDIT_DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [c_idx_w-1:0] owner_q, owner_d;
    logic [SIZE-1:0]    sel_q, sel_d;
    logic               flit_valid_q, flit_valid_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic               err_q, err_d;

    logic               w_can_send;
    logic               w_grant_bad;
    logic               w_take;
    logic               w_serve;
    logic [c_idx_w-1:0] w_grant_idx;
    logic [SIZE-1:0]    w_deq;

    assign w_can_send  = (credits_q != '0);
    assign w_grant_bad = (state_q == ST_IDLE) && (arb_grant != '0) && !$onehot(arb_grant);
    // Success gates the arbiter's priority update, so it must only fire on a real transfer.
    assign w_take      = !rst && (state_q == ST_IDLE) && $onehot(arb_grant) && w_can_send;

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (arb_grant[i]) w_grant_idx = c_idx_w'(i);
        end
    end

    always_comb begin
        w_deq = '0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                if (w_take) w_deq = arb_grant;
            end else if (req_in[owner_q] && w_can_send) begin
                w_deq[owner_q] = 1'b1;
            end
        end
    end

    assign w_serve     = (w_deq != '0);
    assign arb_request = (state_q == ST_IDLE) ? (req_in & {SIZE{w_can_send}}) : '0;
    assign arb_success = w_take;
    assign deq         = w_deq;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        sel_d        = w_serve ? w_deq : sel_q;
        flit_valid_d = w_serve;
        err_d        = err_q | w_grant_bad;
        credits_d    = credits_q;
        case ({w_serve, credit_in})
            2'b10:   credits_d = credits_q - c_one;
            2'b01: begin
                if (credits_q == c_full) err_d = 1'b1;
                else                     credits_d = credits_q + c_one;
            end
            default: credits_d = credits_q;
        endcase
`ifdef OUTPORT_GRANT_CTRL_PKT_LOCK_EN
        if (state_q == ST_IDLE) begin
            if (w_take) begin
                owner_d = w_grant_idx;
                if (!tail_in[w_grant_idx]) state_d = ST_LOCKED;
            end
        end else if (w_serve && tail_in[owner_q]) begin
            state_d = ST_IDLE;
        end
`else
        if (w_take) owner_d = w_grant_idx;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            sel_q        <= '0;
            flit_valid_q <= 1'b0;
            credits_q    <= c_full;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            sel_q        <= sel_d;
            flit_valid_q <= flit_valid_d;
            credits_q    <= credits_d;
            err_q        <= err_d;
        end
    end

    assign sel        = sel_q;
    assign flit_valid = flit_valid_q;
    assign credits    = credits_q;
    assign err        = err_q;

`ifdef OUTPORT_GRANT_CTRL_PKT_LOCK_EN
    assign busy = (state_q == ST_LOCKED);
`else
    logic w_unused_tail;
    assign w_unused_tail = ^tail_in;
    assign busy          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/outport_grant_ctrl.md
# outport_grant_ctrl

Per-output-port switch-allocation control stage that sits directly around a `matrix_arb` instance configured with `multistage=1`. It gates input requests by downstream credit availability and presents them to the arbiter. It consumes the arbiter's one-hot grant, returns a same-cycle `success`, and holds the winning input across a multi-flit packet. It registers the crossbar select and flit-valid for the output port and tracks downstream buffer credits.

## Interface
- `size`, 4: number of input ports; matches the arbiter `size`.
- `credit_depth`, 4: downstream buffer slots; the initial and maximum credit count.
- `cnt_w`, 3: credit counter width; must satisfy `2**cnt_w > credit_depth`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_in`  in  `size`  input i holds a flit for this output.
- `tail_in`  in  `size`  the flit on input i is a tail flit; single-flit packets are head+tail.
- `arb_request`  out  `size`  request vector to the arbiter.
- `arb_grant`  in  `size`  one-hot grant from the arbiter.
- `arb_success`  out  1  to the arbiter `success` input; combinational.
- `deq`  out  `size`  one-hot dequeue to input i this cycle; combinational.
- `sel`  out  `size`  registered one-hot crossbar select.
- `flit_valid`  out  1  registered; a flit crosses the crossbar this cycle.
- `credit_in`  in  1  the downstream buffer freed one slot.
- `credits`  out  `cnt_w`  current credit count.
- `busy`  out  1  a packet lock is held (state LOCKED).
- `err`  out  1  sticky error flag.

## Operation
- `can_send` = (`credits` != 0).
- **IDLE state**
  - `arb_request` = `req_in` & {`size`{`can_send`}}.
  - A grant is taken when `arb_grant` != 0 and `can_send`.
  - On a taken grant: `arb_success`=1 and `deq`=`arb_grant`.
  - The granted index is latched as `owner`.
  - If `tail_in[owner]`=0, go to LOCKED; otherwise stay in IDLE.
- **LOCKED state**
  - `arb_request`=0 and `arb_success`=0.
  - A flit is served when `req_in[owner]` and `can_send`; then `deq[owner]`=1.
  - A served flit with `tail_in[owner]`=1 returns the block to IDLE at the next edge.
- **Serve, both states:** at the next edge, `sel` is loaded with the one-hot of the served input and `flit_valid`=1. With no serve, `flit_valid`=0 and `sel` keeps its value.
- **Credits:** a serve decrements the count and `credit_in` increments it.
  - Serve and `credit_in` in the same cycle leaves the count unchanged.
  - `credit_in` at `credits`=`credit_depth` (with no serve) leaves the count saturated and sets `err`.
- **Grant checks:** a non-one-hot, nonzero `arb_grant` in IDLE sets `err` and is ignored (no serve, `arb_success`=0).
- **`err`:** cleared only by `rst`.
- **Requester drop:** `req_in[owner]` dropping mid-packet keeps the lock; no timeout.

## Timing
- Reset values: state IDLE, `owner`=0, `sel`=0, `flit_valid`=0, `credits`=`credit_depth`, `busy`=0, `err`=0.
- Combinational outputs during reset: `arb_success`=0 and `deq`=0.
- Asserting `rst` mid-packet drops the lock and restores full credits. Upstream and downstream must be reset in the same cycle.
- `arb_request` → `arb_grant` → `arb_success`/`deq`: all in the same cycle, so the arbiter priority updates only on a real transfer.
- Latency from grant (or LOCKED serve) to `sel`/`flit_valid`: 1 cycle.
- Throughput: one flit per cycle while credits last.
- `credits` reflects the previous edge's update; a credit returned in cycle N is usable in cycle N+1.
- `busy` rises at the edge after a non-tail head grant. It falls at the edge after the tail serve.
- A new grant can be taken in the cycle immediately after `busy` falls.

## Configuration
- Macro: `OUTPORT_GRANT_CTRL_PKT_LOCK_EN`.
- **Defined:** wormhole packet lock as described above.
- **Undefined:**
  - LOCKED is never entered; every flit re-arbitrates in IDLE.
  - `tail_in` is ignored and `busy` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- **Reset:** after reset, check `credits`=4, `sel`=0, `flit_valid`=0, `err`=0.
  - Then `req_in`=4'b0100 with `arb_grant`=4'b0100 and head+tail → same-cycle `arb_success`=1, `deq`=4'b0100. Next cycle `sel`=4'b0100, `flit_valid`=1, `credits`=3.
- **Packet lock** (macro on): 3-flit packet on input 1 while input 3 also requests.
  - Expect `arb_request`=0 for 2 cycles and `deq`=4'b0010 for 3 consecutive cycles.
  - `busy` is high for 2 cycles; input 3 is granted in the cycle after the tail.
- **Credit exhaustion:** 5-flit packet with no `credit_in`. Expect 4 flits sent, `credits`=0, then `deq`=0 and stall.
  - One `credit_in` pulse → 5th flit served the following cycle; `credits` ends at 0.
- **Simultaneous serve and credit:** serve plus `credit_in` in the same cycle at `credits`=2 → `credits` stays 2.
  - `credit_in` at `credits`=4 → `credits`=4 and `err`=1 sticky until `rst`.
- **Bad grant:** `arb_grant`=4'b0110 in IDLE → `arb_success`=0, `deq`=0, `err`=1.
- **Macro off:** the same 3-flit packet on input 1 with input 3 requesting → the grant alternates between inputs 1 and 3 flit by flit, and `busy` stays 0.
